ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage_pkg.sv | 64 ++++++
 rtl/wb_skid_buffer.sv | 36 +++
 rtl/ex_wb_stage.sv | 136 +++++++++++++
 tb/tb_ex_wb_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_stage_pkg.sv
// Shared ALU/writeback parameters: datapath widths, opcode encodings, flag indices.
// Latency: n/a (constants and pure combinational helpers only).
// Backpressure: n/a.
package ex_wb_stage_pkg;

  // Datapath widths shared with the ALU.
  localparam int ALUWIDTH = 8;
  localparam int OPSIZE   = 4;
  localparam int NUMFLAGS = 4;
  localparam int REGADDR  = 3;

  // Flag bit positions inside the {C V Z N} vector.
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // ALU opcode encodings; any encoding not listed is a non-ALU operation.
  typedef enum logic [OPSIZE-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_CMP = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_LS  = 4'd5,
    OP_RS  = 4'd6
  } alu_op_e;

  // True for opcodes whose result is written to the register file.
  function automatic logic op_writes_reg(input logic [OPSIZE-1:0] op);
    logic wr;
    wr = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LS, OP_RS: wr = 1'b1;
      default:                                     wr = 1'b0;
    endcase
    return wr;
  endfunction

  // True for opcodes that update the architectural flag register.
  // CMP only sets flags; it never writes a register.
  function automatic logic op_sets_flags(input logic [OPSIZE-1:0] op);
    logic upd;
    upd = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_LS, OP_RS: upd = 1'b1;
      default:                                             upd = 1'b0;
    endcase
    return upd;
  endfunction

  // Assemble a flag vector from individual bits at their architectural positions.
  function automatic logic [NUMFLAGS-1:0] pack_flags(input logic c, input logic v,
                                                     input logic z, input logic n);
    logic [NUMFLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry holding register that catches an entry accepted while the output is stalled.
// Latency: entry pushed at edge N is visible on dout after edge N; popped on a later edge.
// Backpressure: empty is a flop and doubles as the upstream ready (1 = room for one entry).
module wb_skid_buffer #(
  parameter int width = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty
);

  logic [width-1:0] data;

  // Hold one entry; push and pop never coincide because push needs empty and pop needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      empty <= 1'b1;
    end else if (flush) begin
      empty <= 1'b1;
    end else if (push) begin
      data  <= din;
      empty <= 1'b0;
    end else if (pop) begin
      empty <= 1'b1;
    end
  end

  assign dout = data;

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register: registers ALU result, decodes register write enable, owns CVZN flags.
// Latency: one cycle from accept to out_*; retire_count counts output handshakes.
// Backpressure: valid/ready; in_ready = !out_valid || out_ready, or a flopped skid-empty with SKID_BUF_EN.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int aluwidth = ALUWIDTH,
  parameter int opsize   = OPSIZE,
  parameter int numflags = NUMFLAGS,
  parameter int regaddr  = REGADDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [opsize-1:0]   in_opcode,
  input  logic [regaddr-1:0]  in_dest,
  input  logic [aluwidth-1:0] in_result,
  input  logic [numflags-1:0] in_flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [regaddr-1:0]  out_dest,
  output logic [aluwidth-1:0] out_result,
  output logic                out_wen,
  output logic [numflags-1:0] status_flags,
  output logic [15:0]         retire_count
);

  logic                accept;
  logic                retire;
  logic                in_wen;
  logic                in_flag_upd;
  logic                load_out;
  logic [regaddr-1:0]  nxt_dest;
  logic [aluwidth-1:0] nxt_result;
  logic                nxt_wen;

  assign in_wen      = op_writes_reg(in_opcode);
  assign in_flag_upd = op_sets_flags(in_opcode);
  assign accept      = in_valid && in_ready;
  assign retire      = out_valid && out_ready;

`ifdef SKID_BUF_EN
  localparam int entry_w = 1 + regaddr + aluwidth;

  logic               out_free;
  logic               skid_empty;
  logic               skid_push;
  logic               skid_pop;
  logic [entry_w-1:0] skid_dout;

  // Output register can take a new entry this cycle if it is empty or being released.
  assign out_free  = !out_valid || out_ready;
  // An accept that cannot go straight to the output parks in the skid.
  assign skid_push = accept && !out_free && !flush;
  // A parked entry always has priority for the output slot to keep order.
  assign skid_pop  = out_free && !skid_empty && !flush;

  wb_skid_buffer #(
    .width(entry_w)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   ({in_wen, in_dest, in_result}),
    .dout  (skid_dout),
    .empty (skid_empty)
  );

  // Ready comes straight from the skid's empty flop, breaking the combinational ready path.
  assign in_ready = skid_empty;

  // Choose the output source: drained skid entry first, otherwise the incoming entry.
  always_comb begin
    load_out   = out_free && (!skid_empty || accept);
    nxt_wen    = in_wen;
    nxt_dest   = in_dest;
    nxt_result = in_result;
    if (!skid_empty) begin
      {nxt_wen, nxt_dest, nxt_result} = skid_dout;
    end
  end
`else
  // Ready passes through: accept whenever the output slot is empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;

  // Without a skid, the output slot only ever loads the incoming entry.
  always_comb begin
    load_out   = accept;
    nxt_wen    = in_wen;
    nxt_dest   = in_dest;
    nxt_result = in_result;
  end
`endif

  // Output register: flush wins, then a load (covers back-to-back replace), then plain release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_wen    <= 1'b0;
      out_dest   <= '0;
      out_result <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (load_out) begin
      out_valid  <= 1'b1;
      out_wen    <= nxt_wen;
      out_dest   <= nxt_dest;
      out_result <= nxt_result;
    end else if (retire) begin
      out_valid  <= 1'b0;
    end
  end

  // Architectural flags update when an ALU entry is accepted, unless flush drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_flags <= '0;
    end else if (accept && !flush && in_flag_upd) begin
      status_flags <= in_flags;
    end
  end

  // Count every output handshake, including one that coincides with flush; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [2:0] in_dest;
  logic [7:0] in_result;
  logic [3:0] in_flags;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_dest;
  logic [7:0] out_result;
  logic       out_wen;
  logic [3:0] status_flags;
  logic [15:0] retire_count;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] result;
    logic       wen;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   exp_rc;

  ex_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_dest      (in_dest),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dest     (out_dest),
    .out_result   (out_result),
    .out_wen      (out_wen),
    .status_flags (status_flags),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] d,
                       input logic [7:0] r, input logic [3:0] f);
    in_valid  = v;
    in_opcode = op;
    in_dest   = d;
    in_result = r;
    in_flags  = f;
  endtask

  task automatic expect_out(input logic [2:0] d, input logic [7:0] r, input logic w);
    exp_t e;
    e.dest   = d;
    e.result = r;
    e.wen    = w;
    exp_q.push_back(e);
  endtask

  // Monitor: every output handshake pops the oldest expected entry and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected actual=dest%0h/res%0h required=no release", out_dest, out_result);
        end else begin
          e = exp_q.pop_front();
          if (out_dest !== e.dest || out_result !== e.result || out_wen !== e.wen) begin
            errors++;
            $display("FAIL sb_entry actual=d%0h r%0h w%0b required=d%0h r%0h w%0b",
                     out_dest, out_result, out_wen, e.dest, e.result, e.wen);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_rc = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_wen", 32'(out_wen), 0);
    chk("rst_out_dest", 32'(out_dest), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_status", 32'(status_flags), 0);
    chk("rst_retire", 32'(retire_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    tick();

    // ADD dest=2 result=7F flags=0001
    drive(1'b1, OP_ADD, 3'd2, 8'h7F, 4'b0001);
    expect_out(3'd2, 8'h7F, 1'b1);
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    @(negedge clk);
    chk("add_out_valid", 32'(out_valid), 1);
    chk("add_out_wen", 32'(out_wen), 1);
    chk("add_out_result", 32'(out_result), 32'h7F);
    chk("add_status", 32'(status_flags), 32'b0001);
    tick();
    exp_rc = 1;
    @(negedge clk);
    chk("add_retire", 32'(retire_count), 32'(exp_rc));
    chk("add_drained", 32'(out_valid), 0);
    tick();

    // CMP: flags only, no register write
    drive(1'b1, OP_CMP, 3'd3, 8'h00, 4'b0010);
    expect_out(3'd3, 8'h00, 1'b0);
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    @(negedge clk);
    chk("cmp_out_wen", 32'(out_wen), 0);
    chk("cmp_status", 32'(status_flags), 32'b0010);
    tick();

    // Non-ALU opcode: no write, flags unchanged
    drive(1'b1, 4'd9, 3'd4, 8'h5A, 4'b1111);
    expect_out(3'd4, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    @(negedge clk);
    chk("other_out_wen", 32'(out_wen), 0);
    chk("other_status", 32'(status_flags), 32'b0010);
    tick();
    exp_rc = 3;
    @(negedge clk);
    chk("other_retire", 32'(retire_count), 32'(exp_rc));
    tick();

    // Stall with a second entry offered
    out_ready = 1'b0;
    drive(1'b1, OP_AND, 3'd1, 8'h3C, 4'b0100);
    expect_out(3'd1, 8'h3C, 1'b1);
    tick();
    drive(1'b1, OP_OR, 3'd5, 8'hA5, 4'b1000);
    @(negedge clk);
`ifdef SKID_BUF_EN
    chk("stall_in_ready_first", 32'(in_ready), 1);
    expect_out(3'd5, 8'hA5, 1'b1);
`else
    chk("stall_in_ready_first", 32'(in_ready), 0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_dest", 32'(out_dest), 1);
      chk("stall_out_result", 32'(out_result), 32'h3C);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    out_ready = 1'b1;
`ifdef SKID_BUF_EN
    chk("stall_status", 32'(status_flags), 32'b1000);
    exp_rc = 5;
`else
    chk("stall_status", 32'(status_flags), 32'b0100);
    exp_rc = 4;
`endif
    tick();
    @(negedge clk);
`ifdef SKID_BUF_EN
    chk("skid_second_dest", 32'(out_dest), 5);
`endif
    tick();
    @(negedge clk);
    chk("stall_drained", 32'(out_valid), 0);
    chk("stall_retire", 32'(retire_count), 32'(exp_rc));
    tick();

    // Flush with a held entry and a SUB offered in the same cycle
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 3'd4, 8'h11, 4'b0001);
    expect_out(3'd4, 8'h11, 1'b1);
    tick();
    drive(1'b1, OP_SUB, 3'd6, 8'h99, 4'b1000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_status", 32'(status_flags), 32'b0001);
    chk("flush_retire", 32'(retire_count), 32'(exp_rc));
    chk("flush_in_ready", 32'(in_ready), 1);
    tick();

    // Release in the same cycle as flush still counts
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 3'd6, 8'h22, 4'b0001);
    expect_out(3'd6, 8'h22, 1'b1);
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_rc = exp_rc + 1;
    @(negedge clk);
    chk("flush_rel_retire", 32'(retire_count), 32'(exp_rc));
    chk("flush_rel_valid", 32'(out_valid), 0);
    tick();

    // Reset pulsed mid-stall
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 3'd7, 8'h55, 4'b0010);
    expect_out(3'd7, 8'h55, 1'b1);
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_wen", 32'(out_wen), 0);
    chk("midrst_out_dest", 32'(out_dest), 0);
    chk("midrst_out_result", 32'(out_result), 0);
    chk("midrst_status", 32'(status_flags), 0);
    chk("midrst_retire", 32'(retire_count), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // retire_count wrap: 65535 releases then one more
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 4'd7, 3'(i), 8'(i), 4'hF);
      expect_out(3'(i), 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    tick();
    @(negedge clk);
    chk("wrap_ffff", 32'(retire_count), 32'hFFFF);
    chk("wrap_status", 32'(status_flags), 0);
    tick();
    drive(1'b1, OP_RS, 3'd3, 8'h01, 4'b0001);
    expect_out(3'd3, 8'h01, 1'b1);
    tick();
    drive(1'b0, 4'd7, 3'd0, 8'h00, 4'h0);
    tick();
    @(negedge clk);
    chk("wrap_zero", 32'(retire_count), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
